multi_pulse_sync_rx: RTL and testbench

Parametrised receive-side pulse synchronizer for NUM_CH independent event channels. Each channel takes an asynchronous request line from a foreign clock domain and synchronizes it through SYNC_STAGES flops into the local domain. It emits exactly one single-cycle pulse per event and returns a level acknowledge to the sender. Mode is selectable: 2-phase toggle or 4-phase level. It sits on the clk side of every cross-domain control path, for example register-write strobes and DMA-done events crossing into the datapath clock.

---
 rtl/multi_pulse_sync_rx.sv | 83 ++++++++
 tb/tb_multi_pulse_sync_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_sync_rx.sv
// Multi-channel receive-side pulse synchronizer (2-phase toggle or 4-phase level) with ack return.
// Define PULSE_SYNC_EVENT_CNT_EN to build per-channel saturating event counters behind cnt_sel/cnt_clr.
module multi_pulse_sync_rx #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0,
    parameter int CH_SEL_W    = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CH-1:0]      req_in,
    input  logic [NUM_CH-1:0]      ch_en,
    output logic [NUM_CH-1:0]      pulse_out,
    output logic [NUM_CH-1:0]      ack_out,
    output logic                   any_pulse,
    input  logic [CH_SEL_W-1:0]    cnt_sel,
    input  logic                   cnt_clr,
    output logic [COUNT_WIDTH-1:0] cnt_rd_data
);

    logic [NUM_CH-1:0] syncQ [SYNC_STAGES];
    logic [NUM_CH-1:0] d1;
    logic [NUM_CH-1:0] ev;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) syncQ[k] <= '0;
            d1 <= '0;
        end else begin
            syncQ[0] <= req_in;
            for (int k = 1; k < SYNC_STAGES; k++) syncQ[k] <= syncQ[k-1];
            d1 <= syncQ[SYNC_STAGES-1];
        end
    end

    generate
        if (MODE == 0) begin : gToggle
            assign ev = syncQ[SYNC_STAGES-1] ^ d1;
        end else begin : gLevel
            assign ev = syncQ[SYNC_STAGES-1] & ~d1;
        end
    endgenerate

    // d1 keeps tracking while a channel is disabled, so enabling never exposes a stale event
    assign pulse_out = ev & ch_en;
    assign any_pulse = |pulse_out;
    assign ack_out   = d1;

`ifdef PULSE_SYNC_EVENT_CNT_EN
    logic [COUNT_WIDTH-1:0] evCnt [NUM_CH];
    logic [COUNT_WIDTH-1:0] rdNext;

    // Out-of-range selects match no channel: they read 0 and clear nothing
    always_comb begin
        rdNext = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_sel == CH_SEL_W'(i)) rdNext = evCnt[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) evCnt[i] <= '0;
            cnt_rd_data <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_clr && (cnt_sel == CH_SEL_W'(i)))
                    evCnt[i] <= pulse_out[i] ? COUNT_WIDTH'(1) : '0;
                else if (pulse_out[i] && (evCnt[i] != '1))
                    evCnt[i] <= evCnt[i] + 1'b1;
            end
            cnt_rd_data <= rdNext;
        end
    end
`else
    logic unusedCntCtl;
    assign unusedCntCtl = ^{cnt_sel, cnt_clr};
    assign cnt_rd_data  = '0;
`endif

endmodule

// File: tb/tb_multi_pulse_sync_rx.sv
// Scoreboard bench for multi_pulse_sync_rx: a toggle instance (2 stages) and a level instance (3 stages).
// A request-history model predicts pulses, acks and counter reads per cycle.
module tb_multi_pulse_sync_rx;
    localparam int NCH  = 4;
    localparam int SELW = 3;
    localparam int CW   = 4;
    localparam int S0   = 2;
    localparam int S1   = 3;
`ifdef PULSE_SYNC_EVENT_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NCH-1:0]  req_in = '0;
    logic [NCH-1:0]  ch_en = '1;
    logic [SELW-1:0] cnt_sel = '0;
    logic            cnt_clr = 1'b0;
    logic [NCH-1:0]  pulse0, ack0, pulse1, ack1;
    logic            any0, any1;
    logic [CW-1:0]   rd0, rd1;

    always #5 clk = ~clk;

    multi_pulse_sync_rx #(.NUM_CH(NCH), .SYNC_STAGES(S0), .MODE(0), .CH_SEL_W(SELW), .COUNT_WIDTH(CW)) dut0 (
        .clk(clk), .reset(reset), .req_in(req_in), .ch_en(ch_en), .pulse_out(pulse0), .ack_out(ack0),
        .any_pulse(any0), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_rd_data(rd0));

    multi_pulse_sync_rx #(.NUM_CH(NCH), .SYNC_STAGES(S1), .MODE(1), .CH_SEL_W(SELW), .COUNT_WIDTH(CW)) dut1 (
        .clk(clk), .reset(reset), .req_in(req_in), .ch_en(ch_en), .pulse_out(pulse1), .ack_out(ack1),
        .any_pulse(any1), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_rd_data(rd1));

    typedef struct packed {
        logic [NCH-1:0] p0, a0, p1, a1;
        logic [CW-1:0]  r0, r1;
    } exp_t;

    exp_t           expQ[$];
    int             total = 0;
    int             bad = 0;
    logic [NCH-1:0] reqCur = '0;
    logic [NCH-1:0] hist [2][5];
    int             cnt [2][NCH];
    logic [NCH-1:0] evPrev [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, expv);
        end
    endtask

    // hist[d][j] = request vector captured j edges ago; an event is a change (toggle) or
    // rising edge (level) between the values that are SYNC_STAGES-1 and SYNC_STAGES edges old.
    task automatic modelStep(input logic rst);
        exp_t           e;
        logic [NCH-1:0] pAt, ev, p, a;
        logic [CW-1:0]  rd;
        int             sd;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            p = '0; a = '0; rd = '0;
            if (rst) begin
                for (int j = 0; j < 5; j++) hist[d][j] = '0;
                for (int i = 0; i < NCH; i++) cnt[d][i] = 0;
                evPrev[d] = '0;
            end else begin
                pAt = evPrev[d] & ch_en;
                if (CntEn && cnt_sel < NCH) rd = CW'(cnt[d][cnt_sel]);
                for (int i = 0; i < NCH; i++) begin
                    if (CntEn && cnt_clr && cnt_sel == i) cnt[d][i] = pAt[i] ? 1 : 0;
                    else if (CntEn && pAt[i] && cnt[d][i] < (2**CW - 1)) cnt[d][i] = cnt[d][i] + 1;
                end
                for (int j = 4; j > 0; j--) hist[d][j] = hist[d][j-1];
                hist[d][0] = req_in;
                sd = (d == 0) ? S0 : S1;
                if (d == 0) ev = hist[d][sd-1] ^ hist[d][sd];
                else        ev = hist[d][sd-1] & ~hist[d][sd];
                a = hist[d][sd];
                p = ev & ch_en;
                evPrev[d] = ev;
            end
            if (d == 0) begin e.p0 = p; e.a0 = a; e.r0 = rd; end
            else        begin e.p1 = p; e.a1 = a; e.r1 = rd; end
        end
        expQ.push_back(e);
    endtask

    task automatic step(input logic [NCH-1:0] en, input logic [SELW-1:0] sel, input logic clr, input logic rst);
        logic rstPrev;
        @(negedge clk);
        rstPrev = reset;
        req_in = reqCur; ch_en = en; cnt_sel = sel; cnt_clr = clr; reset = rst;
        modelStep(rst);
        if (rst && !rstPrev) begin
            #1;
            chk("rst_ack0", 32'(ack0), 32'd0);
            chk("rst_ack1", 32'(ack1), 32'd0);
            chk("rst_pulse0", 32'(pulse0), 32'd0);
            chk("rst_pulse1", 32'(pulse1), 32'd0);
            chk("rst_rd0", 32'(rd0), 32'd0);
        end
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] en, input logic [SELW-1:0] sel);
        for (int i = 0; i < n; i++) step(en, sel, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("pulse_t", 32'(pulse0), 32'(e.p0));
                chk("ack_t",   32'(ack0),   32'(e.a0));
                chk("any_t",   32'(any0),   32'(|e.p0));
                chk("rd_t",    32'(rd0),    32'(e.r0));
                chk("pulse_l", 32'(pulse1), 32'(e.p1));
                chk("ack_l",   32'(ack1),   32'(e.a1));
                chk("any_l",   32'(any1),   32'(|e.p1));
                chk("rd_l",    32'(rd1),    32'(e.r1));
            end
        end
    end

    initial begin
        logic [NCH-1:0] en;
        logic [SELW-1:0] sel;
        logic clr, rst;
        for (int i = 0; i < 3; i++) step('1, '0, 1'b0, 1'b1);
        idle(4, '1, 3'd1);
        // single toggle up then down on channel 1
        reqCur[1] = 1'b1; idle(10, '1, 3'd1);
        reqCur[1] = 1'b0; idle(10, '1, 3'd1);
        // channel 2 disabled while toggling, then re-enabled
        reqCur[2] = 1'b1; idle(6, 4'b1011, 3'd2);
        reqCur[2] = 1'b0; idle(6, 4'b1011, 3'd2);
        idle(6, '1, 3'd2);
        reqCur[2] = 1'b1; idle(6, '1, 3'd2);
        // all channels at once
        reqCur = ~reqCur; idle(6, '1, 3'd0);
        reqCur = ~reqCur; idle(6, '1, 3'd0);
        // reset one cycle after a capture
        reqCur[0] = ~reqCur[0]; idle(1, '1, 3'd0);
        reqCur = '0;
        step('1, '0, 1'b0, 1'b1);
        step('1, '0, 1'b0, 1'b1);
        idle(5, '1, 3'd0);
        // saturate channel 3 counter
        for (int k = 0; k < 17; k++) begin
            reqCur[3] = ~reqCur[3]; idle(5, '1, 3'd3);
        end
        idle(3, '1, 3'd3);
        // clear in the same cycle as a toggle-instance pulse
        reqCur[3] = ~reqCur[3];
        for (int k = 0; k < 6; k++) step('1, 3'd3, evPrev[0][3], 1'b0);
        idle(3, '1, 3'd3);
        // out-of-range select
        reqCur[3] = ~reqCur[3];
        for (int k = 0; k < 6; k++) step('1, 3'd5, 1'b1, 1'b0);
        idle(3, '1, 3'd3);
        // randomized traffic
        en = '1;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 7) == 0) reqCur[c] = ~reqCur[c];
                if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
            end
            sel = SELW'($urandom_range(0, 7));
            clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 127) == 0);
            if (rst) reqCur = '0;
            step(en, sel, clr, rst);
        end
        idle(6, '1, 3'd0);
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
